// File: rtl/xadc_drp_ctrl.sv
// XADC DRP controller: writes the three config registers after reset, then shares the
// DRP between EOC-driven sample reads and host accesses. Define XADC_DRP_TIMEOUT_EN for the DRP watchdog.
`timescale 1ns/1ps
module xadc_drp_ctrl #(
  parameter logic [15:0] CFG0    = 16'h0000,
  parameter logic [15:0] CFG1    = 16'h2000,
  parameter logic [15:0] CFG2    = 16'h0400,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic [15:0] di_out,
  output logic        init_done,
  output logic [11:0] smp_data,
  output logic [4:0]  smp_chan,
  output logic        smp_valid,
  output logic        smp_overrun,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        drp_err
);

  typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, SMP_WAIT, HOST_WAIT} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        eoc_pend;
  logic [4:0]  pend_chan;
  logic [4:0]  issue_chan;
  logic [15:0] cfg_word;
  logic        timeout_hit;

  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("xadc_drp_ctrl: TIMEOUT must be within 1..1023");
  end

  always_comb begin
    cfg_word = CFG2;
    case (idx)
      2'd0:    cfg_word = CFG0;
      2'd1:    cfg_word = CFG1;
      default: cfg_word = CFG2;
    endcase
  end

`ifdef XADC_DRP_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
  logic [9:0] wait_cnt;
  logic [9:0] wait_eff;
  logic       in_wait;

  // The issue cycle itself counts as wait cycle zero, so the count restarts whenever den_out is high.
  assign wait_eff    = den_out ? 10'd0 : wait_cnt;
  assign in_wait     = (state == INIT_WAIT) || (state == SMP_WAIT) || (state == HOST_WAIT);
  assign timeout_hit = in_wait && !drdy_in && (wait_eff == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= 10'd0;
    else if (wait_eff != 10'h3FF)
      wait_cnt <= wait_eff + 10'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT_ISSUE;
      idx         <= 2'd0;
      eoc_pend    <= 1'b0;
      pend_chan   <= 5'd0;
      issue_chan  <= 5'd0;
      den_out     <= 1'b0;
      dwe_out     <= 1'b0;
      daddr_out   <= 7'd0;
      di_out      <= 16'd0;
      init_done   <= 1'b0;
      smp_data    <= 12'd0;
      smp_chan    <= 5'd0;
      smp_valid   <= 1'b0;
      smp_overrun <= 1'b0;
      host_ack    <= 1'b0;
      host_rdata  <= 16'd0;
      drp_err     <= 1'b0;
    end else begin
      den_out     <= 1'b0;
      dwe_out     <= 1'b0;
      smp_valid   <= 1'b0;
      smp_overrun <= 1'b0;
      host_ack    <= 1'b0;
      drp_err     <= 1'b0;

      // IDLE always consumes a pending EOC, and an EOC with nothing pending in IDLE is read directly.
      if (eoc_in) begin
        pend_chan <= channel_in;
        if (eoc_pend && state != IDLE)
          smp_overrun <= 1'b1;
      end
      if (eoc_in && !(state == IDLE && !eoc_pend))
        eoc_pend <= 1'b1;
      else if (state == IDLE)
        eoc_pend <= 1'b0;

      case (state)
        INIT_ISSUE: begin
          den_out   <= 1'b1;
          dwe_out   <= 1'b1;
          daddr_out <= 7'h40 + {5'd0, idx};
          di_out    <= cfg_word;
          state     <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (drdy_in || timeout_hit) begin
            drp_err <= timeout_hit;
            if (idx == 2'd2) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              idx   <= idx + 2'd1;
              state <= INIT_ISSUE;
            end
          end
        end
        IDLE: begin
          // host_ack high means the host has not yet had a cycle to drop its finished request.
          if (eoc_pend || eoc_in) begin
            den_out    <= 1'b1;
            daddr_out  <= {2'b00, eoc_pend ? pend_chan : channel_in};
            issue_chan <= eoc_pend ? pend_chan : channel_in;
            state      <= SMP_WAIT;
          end else if (host_req && !host_ack) begin
            den_out   <= 1'b1;
            dwe_out   <= host_we;
            daddr_out <= host_addr;
            di_out    <= host_wdata;
            state     <= HOST_WAIT;
          end
        end
        SMP_WAIT: begin
          if (drdy_in) begin
            smp_data  <= do_in[15:4];
            smp_chan  <= issue_chan;
            smp_valid <= 1'b1;
            state     <= IDLE;
          end else if (timeout_hit) begin
            drp_err <= 1'b1;
            state   <= IDLE;
          end
        end
        HOST_WAIT: begin
          if (drdy_in) begin
            host_rdata <= do_in;
            host_ack   <= 1'b1;
            state      <= IDLE;
          end else if (timeout_hit) begin
            drp_err <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_ctrl.sv
// Directed bench for xadc_drp_ctrl against a small DRP register model with 3-cycle drdy latency.
`timescale 1ns/1ps
module tb_xadc_drp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eoc_in = 1'b0;
  logic [4:0]  channel_in = 5'd0;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = 16'hFFFF;
  logic        den_out, dwe_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic        init_done;
  logic [11:0] smp_data;
  logic [4:0]  smp_chan;
  logic        smp_valid, smp_overrun;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [6:0]  host_addr = 7'd0;
  logic [15:0] host_wdata = 16'd0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        drp_err;

  int checks = 0;
  int failures = 0;

  int cyc = 0, den_cnt = 0, den_cyc = -1, eoc_cyc = -1, drdy_cyc = -1;
  int smp_cnt = 0, smp_cyc = -1, ack_cnt = 0, ovr_cnt = 0, err_cnt = 0, err_cyc = -1, init_cyc = -1;
  bit init_seen = 1'b0;
  logic [23:0] den_log[$];

  bit          no_resp = 1'b0;
  bit          mem_ready = 1'b0;
  logic [15:0] mem [128];
  int          cnt_down = 0;
  logic        m_we = 1'b0;
  logic [6:0]  m_addr = 7'd0;
  logic [15:0] m_di = 16'd0;

  xadc_drp_ctrl #(.TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .eoc_in(eoc_in), .channel_in(channel_in),
    .drdy_in(drdy_in), .do_in(do_in), .den_out(den_out), .dwe_out(dwe_out),
    .daddr_out(daddr_out), .di_out(di_out), .init_done(init_done),
    .smp_data(smp_data), .smp_chan(smp_chan), .smp_valid(smp_valid),
    .smp_overrun(smp_overrun), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .drp_err(drp_err)
  );

  always #5 clk = ~clk;

  // Each posedge logs what was present during the cycle that just ended (index cyc).
  always @(posedge clk) begin
    if (rst) begin
      den_log.delete();
      init_seen = 1'b0;
    end
    if (den_out) begin
      den_cnt++;
      den_cyc = cyc;
      den_log.push_back({dwe_out, daddr_out, di_out});
    end
    if (eoc_in) eoc_cyc = cyc;
    if (drdy_in) drdy_cyc = cyc;
    if (smp_valid) begin smp_cnt++; smp_cyc = cyc; end
    if (host_ack) ack_cnt++;
    if (smp_overrun) ovr_cnt++;
    if (drp_err) begin err_cnt++; err_cyc = cyc; end
    if (init_done && !init_seen) begin init_seen = 1'b1; init_cyc = cyc; end
    cyc++;
  end

  // DRP register model: drdy_in is high during the third cycle after the den_out cycle.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
      mem[1] = 16'h1110; mem[2] = 16'h2220; mem[3] = 16'hABC0; mem[7] = 16'h7770;
      mem_ready = 1'b1;
    end
    drdy_in = 1'b0;
    do_in   = 16'hFFFF;
    if (cnt_down > 0) begin
      cnt_down--;
      if (cnt_down == 0) begin
        drdy_in = 1'b1;
        do_in   = m_we ? 16'h0000 : mem[m_addr];
        if (m_we) mem[m_addr] = m_di;
      end
    end
    if (den_out && !no_resp) begin
      m_we = dwe_out; m_addr = daddr_out; m_di = di_out; cnt_down = 3;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, s, o, dn, ec, lsz;
    logic [23:0] e;

    repeat (3) step();
    check_output("rst_den", {den_out, dwe_out}, 32'h0);
    check_output("rst_init_done", init_done, 32'h0);
    check_output("rst_pulses", {smp_valid, smp_overrun, host_ack, drp_err}, 32'h0);
    check_output("rst_addr_data", {daddr_out, di_out}, 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 100 && !init_seen; i++) step();
    check_output("init_done_seen", init_seen, 32'h1);
    check_output("init_writes", den_log.size(), 32'd3);
    e = den_log[0]; check_output("init_wr0", e, 32'hC00000);
    e = den_log[1]; check_output("init_wr1", e, 32'hC12000);
    e = den_log[2]; check_output("init_wr2", e, 32'hC20400);
    check_output("init_done_timing", init_cyc, drdy_cyc + 1);

    step();
    n = smp_cnt;
    eoc_in = 1'b1; channel_in = 5'h03;
    step();
    eoc_in = 1'b0;
    for (int i = 0; i < 50 && smp_cnt == n; i++) step();
    check_output("smp1_count", smp_cnt, n + 1);
    check_output("smp1_den_latency", den_cyc, eoc_cyc + 1);
    e = den_log[den_log.size() - 1];
    check_output("smp1_read_addr", e[23:16], 32'h03);
    check_output("smp1_data", smp_data, 32'hABC);
    check_output("smp1_chan", smp_chan, 32'h3);
    check_output("smp1_valid_timing", smp_cyc, drdy_cyc + 1);

    n = ack_cnt;
    host_we = 1'b1; host_addr = 7'h40; host_wdata = 16'h5A5A; host_req = 1'b1;
    for (int i = 0; i < 50 && ack_cnt == n; i++) step();
    host_req = 1'b0;
    repeat (4) step();
    check_output("hwr_ack_count", ack_cnt, n + 1);
    e = den_log[den_log.size() - 1];
    check_output("hwr_issue", e, 32'hC05A5A);

    lsz = den_log.size(); n = ack_cnt; s = smp_cnt;
    eoc_in = 1'b1; channel_in = 5'h07;
    host_we = 1'b0; host_addr = 7'h40; host_req = 1'b1;
    step();
    eoc_in = 1'b0;
    for (int i = 0; i < 80 && ack_cnt == n; i++) step();
    host_req = 1'b0;
    repeat (6) step();
    check_output("arb_ack_count", ack_cnt, n + 1);
    check_output("arb_smp_count", smp_cnt, s + 1);
    check_output("arb_den_count", den_log.size(), lsz + 2);
    e = den_log[lsz];     check_output("arb_first_is_sample", e[23:16], 32'h07);
    e = den_log[lsz + 1]; check_output("arb_second_is_host", e[23:16], 32'h40);
    check_output("arb_host_rdata", host_rdata, 32'h5A5A);
    check_output("arb_smp", {smp_chan, smp_data}, {5'h07, 12'h777});

    o = ovr_cnt; s = smp_cnt; n = ack_cnt; dn = den_cnt;
    host_we = 1'b0; host_addr = 7'h41; host_req = 1'b1;
    for (int i = 0; i < 20 && den_cnt == dn; i++) step();
    eoc_in = 1'b1; channel_in = 5'h01;
    step();
    channel_in = 5'h02;
    step();
    eoc_in = 1'b0;
    for (int i = 0; i < 50 && ack_cnt == n; i++) step();
    host_req = 1'b0;
    for (int i = 0; i < 50 && smp_cnt == s; i++) step();
    repeat (6) step();
    check_output("ovr_count", ovr_cnt, o + 1);
    check_output("ovr_host_rdata", host_rdata, 32'h2000);
    check_output("ovr_single_sample", smp_cnt, s + 1);
    check_output("ovr_newest_chan", {smp_chan, smp_data}, {5'h02, 12'h222});

    s = smp_cnt; dn = den_cnt;
    eoc_in = 1'b1; channel_in = 5'h03;
    step();
    eoc_in = 1'b0;
    for (int i = 0; i < 20 && den_cnt == dn; i++) step();
    rst = 1'b1;
    #1;
    check_output("mrst_den", den_out, 32'h0);
    check_output("mrst_init_done", init_done, 32'h0);
    check_output("mrst_outputs", {smp_chan, smp_data, host_rdata, daddr_out}, 32'h0);
    repeat (4) step();
    rst = 1'b0;
    for (int i = 0; i < 100 && !init_seen; i++) step();
    repeat (3) step();
    check_output("mrst_reinit", init_seen, 32'h1);
    check_output("mrst_no_stale_sample", smp_cnt, s);
    e = den_log[0]; check_output("mrst_first_write", e, 32'hC00000);

`ifdef XADC_DRP_TIMEOUT_EN
    no_resp = 1'b1;
    n = ack_cnt; ec = err_cnt; dn = den_cnt;
    host_we = 1'b0; host_addr = 7'h41; host_req = 1'b1;
    for (int i = 0; i < 20 && den_cnt == dn; i++) step();
    repeat (8) step();
    host_req = 1'b0;
    for (int i = 0; i < 40 && err_cnt == ec; i++) step();
    no_resp = 1'b0;
    repeat (4) step();
    check_output("tmo_err_count", err_cnt, ec + 1);
    check_output("tmo_err_timing", err_cyc, den_cyc + 10);
    check_output("tmo_no_ack", ack_cnt, n);
    check_output("tmo_no_reissue", den_cnt, dn + 1);
    s = smp_cnt;
    eoc_in = 1'b1; channel_in = 5'h03;
    step();
    eoc_in = 1'b0;
    for (int i = 0; i < 50 && smp_cnt == s; i++) step();
    check_output("tmo_next_eoc", smp_cnt, s + 1);
    check_output("tmo_next_data", smp_data, 32'hABC);
`else
    check_output("no_drp_err", err_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
